// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM elastic pipeline register: a main slot (M) drives the MEM stage and a
// skid slot (S) absorbs one extra entry, so MEM stalls never feed a combinational
// ready path back into EXE.
// Latency: 1 cycle. Backpressure: in_ready drops only when both slots are full.
//
// Optional feature macro: EXE_MEM_FWD_EN adds fwd_wb_en / fwd_dest / fwd_data
// for the forwarding unit. The default build leaves it out.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                synchronous squash of all held entries
//   in_valid / in_ready  EXE-side handshake (in_ready decoded from state only)
//   *_in                 WB_EN, MEM_R_EN, MEM_W_EN, alu_result, Val_Rm, Dest from EXE
//   out_valid/out_ready  MEM-side handshake
//   *_out                held entry in M; control bits qualified by out_valid
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [DEST_W-1:0] Dest_out
`ifdef EXE_MEM_FWD_EN
  ,
  output logic              fwd_wb_en,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
  } entry_t;

  state_t state;
  entry_t m_q;
  entry_t s_q;
  entry_t in_ent;
  logic   accept;
  logic   drain;

  assign in_ent = {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, alu_result_in, Val_Rm_in, Dest_in};

  // Both handshake outputs depend on the state register alone.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      // Squash: any same-cycle accept is dropped. Data fields are kept so the
      // outputs keep showing the last M value while empty.
      state      <= EMPTY;
      m_q.wb_en    <= 1'b0;
      m_q.mem_r_en <= 1'b0;
      m_q.mem_w_en <= 1'b0;
      s_q.wb_en    <= 1'b0;
      s_q.mem_r_en <= 1'b0;
      s_q.mem_w_en <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_q   <= in_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_q <= in_ent;
          end else if (accept) begin
            // MEM stalled: park the newer entry behind M to keep order.
            s_q   <= in_ent;
            state <= FULL;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            m_q   <= s_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign WB_EN_out      = m_q.wb_en    & out_valid;
  assign MEM_R_EN_out   = m_q.mem_r_en & out_valid;
  assign MEM_W_EN_out   = m_q.mem_w_en & out_valid;
  assign alu_result_out = m_q.alu_result;
  assign Val_Rm_out     = m_q.val_rm;
  assign Dest_out       = m_q.dest;

`ifdef EXE_MEM_FWD_EN
  assign fwd_wb_en = m_q.wb_en & out_valid;
  assign fwd_dest  = m_q.dest;
  assign fwd_data  = m_q.alu_result;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: a vector table of {inputs, expected
// outputs after the next rising edge}, then a stalled-stream ordering sequence
// and, when EXE_MEM_FWD_EN is defined, a forwarding-port sequence.
module tb_exe_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
  logic [31:0] alu_result_in, Val_Rm_in, alu_result_out, Val_Rm_out;
  logic [3:0]  Dest_in, Dest_out;
`ifdef EXE_MEM_FWD_EN
  logic        fwd_wb_en;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .alu_result_in(alu_result_in), .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .alu_result_out(alu_result_out), .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out)
`ifdef EXE_MEM_FWD_EN
    ,
    .fwd_wb_en(fwd_wb_en), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
  );

  typedef struct packed {
    logic        rst, flush, iv, ordy, wb, mr, mw;
    logic [31:0] alu, val;
    logic [3:0]  dest;
  } in_t;

  typedef struct packed {
    logic        ov, ir, wb, mr, mw;
    logic [31:0] alu, val;
    logic [3:0]  dest;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic apply(input in_t v);
    rst = v.rst; flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
    WB_EN_in = v.wb; MEM_R_EN_in = v.mr; MEM_W_EN_in = v.mw;
    alu_result_in = v.alu; Val_Rm_in = v.val; Dest_in = v.dest;
  endtask

  task automatic chk_out(input int idx, input out_t exp_o);
    out_t act;
    act = {out_valid, in_ready, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
           alu_result_out, Val_Rm_out, Dest_out};
    n_checks++;
    if (act !== exp_o) begin
      n_fail++;
      $display("FAIL vec%0d: got ov=%b ir=%b wb=%b mr=%b mw=%b alu=%h val=%h dest=%h, expected ov=%b ir=%b wb=%b mr=%b mw=%b alu=%h val=%h dest=%h",
               idx, act.ov, act.ir, act.wb, act.mr, act.mw, act.alu, act.val, act.dest,
               exp_o.ov, exp_o.ir, exp_o.wb, exp_o.mr, exp_o.mw, exp_o.alu, exp_o.val, exp_o.dest);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  initial begin
    //            rst   flush iv    ordy  wb    mr    mw    alu           val           dest      ov    ir    wb    mr    mw    alu          val           dest
    // reset held two cycles with in_valid high
    vecs[0]  = '{'{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'hDEAD,32'hBEEF,4'd5}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,   4'd0}};
    vecs[1]  = '{'{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'hDEAD,32'hBEEF,4'd5}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,   4'd0}};
    // bubble: fields driven but never captured
    vecs[2]  = '{'{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h77,  32'h88,  4'd7}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,   4'd0}};
    // streaming with out_ready high
    vecs[3]  = '{'{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h10,  32'hA10, 4'd1}, '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h10, 32'hA10, 4'd1}};
    vecs[4]  = '{'{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,32'h20,  32'hA20, 4'd2}, '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h20, 32'hA20, 4'd2}};
    vecs[5]  = '{'{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h30,  32'hA30, 4'd3}, '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h30, 32'hA30, 4'd3}};
    vecs[6]  = '{'{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h99,  32'h99,  4'd9}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h30, 32'hA30, 4'd3}};
    // backpressure: fill to FULL, blocked offer, then drain in order
    vecs[7]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'hA,   32'hB0A, 4'd4}, '{1'b1,1'b1,1'b1,1'b0,1'b0,32'hA,  32'hB0A, 4'd4}};
    vecs[8]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'hB,   32'hB0B, 4'd5}, '{1'b1,1'b0,1'b1,1'b0,1'b0,32'hA,  32'hB0A, 4'd4}};
    vecs[9]  = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,32'hC,   32'hB0C, 4'd6}, '{1'b1,1'b0,1'b1,1'b0,1'b0,32'hA,  32'hB0A, 4'd4}};
    vecs[10] = '{'{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,   4'd0}, '{1'b1,1'b1,1'b1,1'b0,1'b0,32'hB,  32'hB0B, 4'd5}};
    vecs[11] = '{'{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,   4'd0}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'hB,  32'hB0B, 4'd5}};
    // flush from FULL with store entries, then a fresh entry
    vecs[12] = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h100, 32'hF100,4'd6}, '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h100,32'hF100,4'd6}};
    vecs[13] = '{'{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h200, 32'hF200,4'd7}, '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h100,32'hF100,4'd6}};
    vecs[14] = '{'{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,   4'd0}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h100,32'hF100,4'd6}};
    vecs[15] = '{'{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h55,  32'hC55, 4'd8}, '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h55, 32'hC55, 4'd8}};
    // flush together with accept and drain: accept is discarded
    vecs[16] = '{'{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,32'h66,  32'hC66, 4'd9}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h55, 32'hC55, 4'd8}};
    vecs[17] = '{'{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,   4'd0}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h55, 32'hC55, 4'd8}};
    // reset (with flush and handshake) in FULL discards both entries
    vecs[18] = '{'{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,32'h301, 32'hD01, 4'd1}, '{1'b1,1'b1,1'b1,1'b1,1'b0,32'h301,32'hD01, 4'd1}};
    vecs[19] = '{'{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h302, 32'hD02, 4'd2}, '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h301,32'hD01, 4'd1}};
    vecs[20] = '{'{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,32'h303, 32'hD03, 4'd3}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,   4'd0}};
    vecs[21] = '{'{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,   4'd0}, '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,   4'd0}};

    apply('0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k].i);
      @(posedge clk);
      #1;
      chk_out(k, vecs[k].e);
    end

    // Ordering under a toggling out_ready: EXE offers 1..8 whenever it can.
    begin
      int sent = 0;
      int rcvd = 0;
      apply('0);
      for (int c = 0; c < 100 && rcvd < 8; c++) begin
        out_ready     = (c % 3) != 0;
        in_valid      = (sent < 8);
        alu_result_in = sent + 1;
        Val_Rm_in     = 32'hE00 + sent + 1;
        #1;
        if (out_valid && out_ready) begin
          chk32($sformatf("order%0d", rcvd), alu_result_out, rcvd + 1);
          rcvd++;
        end
        if (in_valid && in_ready) sent++;
        @(posedge clk);
        #1;
      end
      chk32("order_count", rcvd, 8);
    end

`ifdef EXE_MEM_FWD_EN
    apply('0);
    in_valid = 1'b1; WB_EN_in = 1'b1; Dest_in = 4'd3; alu_result_in = 32'h1234;
    @(posedge clk);
    #1;
    in_valid = 1'b0; WB_EN_in = 1'b0;
    chk32("fwd_wb_en_held", {31'd0, fwd_wb_en}, 32'd1);
    chk32("fwd_dest_held", {28'd0, fwd_dest}, 32'd3);
    chk32("fwd_data_held", fwd_data, 32'h1234);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk32("fwd_wb_en_empty", {31'd0, fwd_wb_en}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
- Parametrised EXE->MEM pipeline register for the ARM core.
- Replaces the fixed 32-bit always-load EXE stage register with an elastic two-entry (main plus skid) register.
- Adds a valid/ready handshake and a synchronous flush, so memory-side stalls do not create a combinational ready path back into EXE.
- Sits between the EXE stage (ALU, Val_Rm mux) and the MEM stage (data memory, SRAM controller).

Parameters:
- DATA_W, 32, width of the ALU result and Val_Rm datapath.
- DEST_W, 4, width of the destination register index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EXE presents an instruction.
- in_ready  out  1  register can accept; decoded from state registers only.
- WB_EN_in  in  1  write-back enable.
- MEM_R_EN_in  in  1  memory read enable.
- MEM_W_EN_in  in  1  memory write enable.
- alu_result_in  in  DATA_W  ALU result / memory address.
- Val_Rm_in  in  DATA_W  store data.
- Dest_in  in  DEST_W  destination register.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage consumes the entry this cycle.
- WB_EN_out, MEM_R_EN_out, MEM_W_EN_out  out  1 each  control bits, qualified by out_valid.
- alu_result_out  out  DATA_W  held ALU result.
- Val_Rm_out  out  DATA_W  held store data.
- Dest_out  out  DEST_W  held destination.

Behaviour:
- Storage and handshake
  - Two slots: M drives the outputs; S is the skid slot.
  - accept = in_valid & in_ready; drain = out_valid & out_ready.
  - FSM states: EMPTY, ONE (M valid), FULL (M and S valid).
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Transitions
  - EMPTY: accept -> ONE, M <= inputs; otherwise stay.
  - ONE: accept & drain -> ONE, M <= inputs. Accept & !drain -> FULL, S <= inputs. Drain only -> EMPTY. Neither -> hold.
  - FULL: drain -> ONE, M <= S. No accept is possible (in_ready = 0). No drain -> hold.
- Timing and ordering
  - Latency is 1 cycle: an input accepted in EMPTY state appears on the outputs the next cycle.
  - Throughput is 1 per cycle while out_ready = 1.
  - Program order is always preserved.
- Control qualification
  - WB_EN_out, MEM_R_EN_out and MEM_W_EN_out are forced to 0 whenever out_valid = 0.
  - Data and Dest outputs hold their last M value when empty.
- Reset
  - rst = 1 at a clock edge gives state EMPTY and clears M and S completely.
  - All outputs read 0 after reset; in_ready = 1.
  - Reset has priority over flush and over any handshake.
  - Reset mid-FULL discards both entries.
- Flush
  - flush = 1 at a clock edge (rst = 0) gives state EMPTY and clears all control bits.
  - An accept in the same cycle is discarded; a drain in the same cycle still counts as consumed by MEM.
  - in_ready = 1 on the next cycle.
- Bubbles
  - in_valid = 0 means the input fields are don't-care and are never captured.
  - Values on the input fields while in_valid = 0 must not reach the outputs.

Optional Feature:
- Macro: EXE_MEM_FWD_EN.
- When defined, the block adds three outputs for the forwarding unit:
  - fwd_wb_en (1): WB_EN of the entry in M, ANDed with out_valid.
  - fwd_dest (DEST_W): Dest of the entry in M.
  - fwd_data (DATA_W): alu_result of the entry in M.
- When undefined, these ports and their logic are absent.
- The core behaviour is identical either way.

Test Plan:
1. Reset: hold rst = 1 for 2 cycles with in_valid = 1 -> out_valid = 0, all outputs 0, in_ready = 1 the cycle after release.
2. Streaming: out_ready = 1, send alu_result 0x10, 0x20, 0x30 on consecutive cycles -> outputs show 0x10, 0x20, 0x30 one cycle later each; in_ready stays 1.
3. Backpressure: out_ready = 0, send 0xA then 0xB -> state FULL, in_ready = 0, output holds 0xA. Then raise out_ready -> 0xA, 0xB delivered in order, in_ready = 1 again.
4. Flush: in FULL state with MEM_W_EN = 1 entries, pulse flush -> next cycle out_valid = 0, MEM_W_EN_out = 0, in_ready = 1; subsequent input 0x55 delivered normally.
5. Bubble: in_valid = 0 with WB_EN_in = 1 and Dest_in = 7 -> out_valid = 0 and WB_EN_out = 0; no capture occurs.
6. With EXE_MEM_FWD_EN: hold entry WB_EN = 1, Dest = 3, alu_result 0x1234 in M -> fwd_wb_en = 1, fwd_dest = 3, fwd_data = 0x1234; after drain to empty, fwd_wb_en = 0.
